serial_parity_checker: RTL and testbench
========================================

# serial_parity_checker

Serial-to-parallel frame receiver with parity check. It is the receiving end of the team's serial parity-generation path. It deserializes one frame per transfer (start bit, DATA_W data bits LSB first, parity bit, stop bit), one bit per sin_valid strobe. It presents the word with parity/framing error flags and keeps a saturating error count for the status block.

## Interface
- DATA_W, 8: data bits per frame; legal range 1..16.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity.
- clk  input  1  clock; all logic rising-edge.
- arstn  input  1  reset: asynchronous, active-low.
- sin  input  1  serial data bit; sampled only when sin_valid=1.
- sin_valid  input  1  bit strobe; 1 = sin holds a new bit this cycle.
- err_clr  input  1  synchronous clear of err_cnt.
- dout  output  DATA_W  received word; holds its value until the next frame completes.
- dout_valid  output  1  one-cycle pulse when a frame completes.
- par_err  output  1  parity mismatch for the frame shown on dout; valid while dout_valid=1.
- frm_err  output  1  stop bit was 0; valid while dout_valid=1.
- err_cnt  output  8  frames with par_err or frm_err set, saturating at 255.
- busy  output  1  1 in any state other than IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on cycles with sin_valid=1. With sin_valid=0 the FSM and all registers hold.
- IDLE: sin=0 is the start bit; move to DATA, clear the bit counter and the running parity. sin=1 keeps IDLE (line idle).
- DATA: shift sin into bit position bit_cnt (LSB first) and XOR sin into the running parity. After bit DATA_W-1, move to PARITY.
- PARITY: expected parity bit = running XOR, inverted when PARITY_ODD=1. Latch (sin != expected) as pending parity error. Move to STOP.
- STOP: load dout from the shift register, set par_err to the pending value, set frm_err = ~sin, pulse dout_valid. Return to IDLE. A 0 stop bit is never treated as the next start bit.
- err_cnt increments by exactly 1 per frame when par_err|frm_err, including frames with both errors. It holds at 255.
- err_clr together with an increment in the same cycle gives err_cnt=1. err_clr alone gives err_cnt=0.
- par_err and frm_err are cleared to 0 when dout_valid deasserts. They only carry meaning while dout_valid=1.

## Timing
- Reset (arstn=0, any time, including mid-frame):
  - State = IDLE; bit counter, shift register and running parity = 0.
  - dout=0, dout_valid=0, par_err=0, frm_err=0, err_cnt=0, busy=0.
  - A partial frame is discarded; no dout_valid is produced for it.
- All outputs are registered.
- dout, dout_valid, par_err and frm_err update on the edge that samples the stop bit, so they are visible the following cycle. dout_valid is high for exactly one cycle.
- err_cnt updates on the same edge as dout_valid.
- Minimum frame length is DATA_W+3 sin_valid strobes. Back-to-back frames are supported: a start bit may arrive on the strobe immediately after the stop bit.
- busy rises the cycle after the start bit is sampled and falls the cycle after the stop bit is sampled.
- Gaps of any length between strobes do not change the result.

## Structure
- Shared package:
  - state enum (IDLE/DATA/PARITY/STOP, 2-bit encoding);
  - PAR_EVEN=0 / PAR_ODD=1 constants;
  - ERR_CNT_W=8.
- Bit counter width is $clog2(DATA_W).
- One sub-module is natural: err_sat_counter (8-bit saturating counter with increment input and synchronous clear; clear-with-increment yields 1).

## Test plan
- DATA_W=8, even parity. Frame 0, bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0, stop 1, sin_valid continuous -> dout=0xA5, one-cycle dout_valid, par_err=0, frm_err=0, err_cnt=0.
- Same frame with parity bit 1 -> par_err=1, frm_err=0, err_cnt=1. Repeat with PARITY_ODD=1 and parity 1 -> no error.
- Frame 0x3C, correct parity, stop 0 -> frm_err=1, err_cnt increments. A following valid 0x01 frame sent immediately -> dout=0x01, no errors.
- Random idle gaps of 0-5 cycles between strobes across a 0xFF frame, plus idle 1s before the start bit -> dout=0xFF, no errors, dout_valid exactly once.
- arstn pulsed low after the 4th data bit, then a full 0x5A frame -> no output for the aborted frame; dout=0x5A, err_cnt=0.
- 256 bad-parity frames -> err_cnt=255 and stays there. err_clr asserted on the dout_valid cycle of a bad frame -> err_cnt=1.

Source files
------------

// File: rtl/serial_parity_checker_pkg.sv
// Shared types and constants for the serial parity receive path.
//   state_e   : receiver FSM states (2-bit encoding)
//   PAR_EVEN  : parity mode select value for even parity
//   PAR_ODD   : parity mode select value for odd parity
//   ERR_CNT_W : width of the saturating error counter
package serial_parity_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_e;

   localparam int unsigned PAR_EVEN  = 0;
   localparam int unsigned PAR_ODD   = 1;
   localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial line in / parallel word out bundle for the parity checker.
//   master : drives sin, sin_valid, err_clr; observes received word and status
//   slave  : the receiver; consumes the serial strobes and drives the results
interface serial_parity_checker_if
   import serial_parity_checker_pkg::*;
#(
   parameter int unsigned DATA_W = 8
);

   logic                 sin;
   logic                 sin_valid;
   logic                 err_clr;
   logic [DATA_W-1:0]    dout;
   logic                 dout_valid;
   logic                 par_err;
   logic                 frm_err;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic                 busy;

   modport master (
      output sin, sin_valid, err_clr,
      input  dout, dout_valid, par_err, frm_err, err_cnt, busy
   );

   modport slave (
      input  sin, sin_valid, err_clr,
      output dout, dout_valid, par_err, frm_err, err_cnt, busy
   );

endinterface

// File: rtl/serial_parity_checker_err_sat_counter.sv
// Saturating error counter for the status block.
//   clk, arstn : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear; clear together with inc leaves the count at 1
//   cnt        : current count, holds at all-ones
module err_sat_counter
   import serial_parity_checker_pkg::*;
(
   input  logic                 clk,
   input  logic                 arstn,
   input  logic                 inc,
   input  logic                 clr,
   output logic [ERR_CNT_W-1:0] cnt
);

   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins over the stored value but still records a coincident event
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = inc ? ERR_CNT_W'(1) : '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit,
// stop bit, one bit per sin_valid strobe. Presents the word with parity and
// framing error flags and keeps a saturating count of bad frames.
//   clk, arstn : clock, asynchronous active-low reset
//   bus.sin, bus.sin_valid : serial bit and its strobe
//   bus.err_clr            : synchronous clear of err_cnt
//   bus.dout, bus.dout_valid, bus.par_err, bus.frm_err : received frame result
//   bus.err_cnt            : bad-frame count, saturating
//   bus.busy               : receiver is inside a frame
module serial_parity_checker
   import serial_parity_checker_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PARITY_ODD = PAR_EVEN
) (
   input  logic                   clk,
   input  logic                   arstn,
   serial_parity_checker_if.slave bus
);

   // A 1-bit word still needs a 1-bit counter
   localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic        PAR_INV = (PARITY_ODD == PAR_ODD);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]    shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 par_pend_q, par_pend_d;
   logic [DATA_W-1:0]    dout_q, dout_d;
   logic                 dout_valid_q, dout_valid_d;
   logic                 par_err_q, par_err_d;
   logic                 frm_err_q, frm_err_d;
   logic                 busy_q, busy_d;
   logic                 err_inc_c;
   logic [ERR_CNT_W-1:0] err_cnt;

   // Frame FSM and datapath next-state; everything advances only on a strobe
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      par_d        = par_q;
      par_pend_d   = par_pend_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      par_err_d    = 1'b0;
      frm_err_d    = 1'b0;
      err_inc_c    = 1'b0;

      if (bus.sin_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (!bus.sin) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
                  par_d     = 1'b0;
               end
            end
            ST_DATA: begin
               for (int unsigned i = 0; i < DATA_W; i++) begin
                  if (bit_cnt_q == CNT_W'(i)) begin
                     shreg_d[i] = bus.sin;
                  end
               end
               par_d     = par_q ^ bus.sin;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               par_pend_d = (bus.sin != (par_q ^ PAR_INV));
               state_d    = ST_STOP;
            end
            ST_STOP: begin
               // A low stop bit is a framing error, never a new start bit
               dout_d       = shreg_q;
               par_err_d    = par_pend_q;
               frm_err_d    = ~bus.sin;
               dout_valid_d = 1'b1;
               err_inc_c    = par_pend_q | ~bus.sin;
               state_d      = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         par_pend_q   <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         frm_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         par_pend_q   <= par_pend_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         par_err_q    <= par_err_d;
         frm_err_q    <= frm_err_d;
         busy_q       <= busy_d;
      end
   end

   err_sat_counter u_err_cnt (
      .clk   (clk),
      .arstn (arstn),
      .inc   (err_inc_c),
      .clr   (bus.err_clr),
      .cnt   (err_cnt)
   );

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.par_err    = par_err_q;
   assign bus.frm_err    = frm_err_q;
   assign bus.err_cnt    = err_cnt;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: an even-parity and an odd-parity receiver
// see the same serial stream; expected frame results are queued at the stop
// strobe and popped by a negedge monitor whenever dout_valid is seen.
module tb_serial_parity_checker;
   import serial_parity_checker_pkg::*;

   localparam int unsigned DW = 8;

   typedef struct {
      logic [DW-1:0] dout;
      logic          par_err;
      logic          frm_err;
      int            err_cnt;
   } exp_t;

   logic clk   = 1'b0;
   logic arstn = 1'b0;

   always #5 clk = ~clk;

   serial_parity_checker_if #(.DATA_W(DW)) bus_e ();
   serial_parity_checker_if #(.DATA_W(DW)) bus_o ();

   serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(PAR_EVEN)) dut_e (
      .clk   (clk),
      .arstn (arstn),
      .bus   (bus_e)
   );

   serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(PAR_ODD)) dut_o (
      .clk   (clk),
      .arstn (arstn),
      .bus   (bus_o)
   );

   exp_t q_e[$];
   exp_t q_o[$];
   exp_t me, mo;
   int   n_vec = 0;
   int   n_mis = 0;
   int   cnt_e = 0;
   int   cnt_o = 0;

   function automatic void chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference error count: clear wins but records a coincident bad frame
   function automatic int next_cnt(input int cnt, input bit bad, input bit clr);
      if (clr) return bad ? 1 : 0;
      if (bad && cnt < 255) return cnt + 1;
      return cnt;
   endfunction

   // Apply one cycle of inputs to both receivers
   task automatic drive(input logic v, input logic s, input logic c);
      bus_e.sin_valid = v; bus_o.sin_valid = v;
      bus_e.sin       = s; bus_o.sin       = s;
      bus_e.err_clr   = c; bus_o.err_clr   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int max_gap);
      int n;
      n = $urandom_range(max_gap, 0);
      repeat (n) drive(1'b0, 1'($urandom), 1'b0);
   endtask

   task automatic send_frame(input logic [DW-1:0] data, input logic pbit, input logic stop,
                             input int max_gap, input int idle_ones, input bit clr);
      exp_t e;
      bit   pe_e, pe_o, fe;
      int   ones;
      ones = 0;
      for (int i = 0; i < int'(DW); i++) ones += int'(data[i]);
      pe_e = (pbit != 1'((ones % 2) != 0));
      pe_o = (pbit != 1'((ones % 2) == 0));
      fe   = !stop;

      repeat (idle_ones) begin
         gap(max_gap);
         drive(1'b1, 1'b1, 1'b0);
      end
      gap(max_gap);
      drive(1'b1, 1'b0, 1'b0);
      chk("busy_after_start", int'(bus_e.busy), 1);
      for (int i = 0; i < int'(DW); i++) begin
         gap(max_gap);
         drive(1'b1, data[i], 1'b0);
      end
      gap(max_gap);
      drive(1'b1, pbit, 1'b0);
      gap(max_gap);

      cnt_e = next_cnt(cnt_e, pe_e | fe, clr);
      cnt_o = next_cnt(cnt_o, pe_o | fe, clr);
      e.dout = data; e.frm_err = fe;
      e.par_err = pe_e; e.err_cnt = cnt_e; q_e.push_back(e);
      e.par_err = pe_o; e.err_cnt = cnt_o; q_o.push_back(e);
      drive(1'b1, stop, 1'(clr));
      chk("busy_after_stop", int'(bus_e.busy), 0);
   endtask

   task automatic do_reset();
      arstn = 1'b0;
      cnt_e = 0;
      cnt_o = 0;
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("rst_dout",       int'(bus_e.dout),       0);
      chk("rst_dout_valid", int'(bus_e.dout_valid), 0);
      chk("rst_par_err",    int'(bus_e.par_err),    0);
      chk("rst_frm_err",    int'(bus_e.frm_err),    0);
      chk("rst_err_cnt",    int'(bus_e.err_cnt),    0);
      chk("rst_busy",       int'(bus_e.busy),       0);
      chk("rst_odd_busy",   int'(bus_o.busy),       0);
      arstn = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard monitor: compare every presented frame, flags must be low otherwise
   always @(negedge clk) begin
      if (bus_e.dout_valid) begin
         if (q_e.size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL even_unexpected_dout_valid: got dout 0x%0h, expected no frame (t=%0t)",
                     bus_e.dout, $time);
         end else begin
            me = q_e.pop_front();
            chk("even_dout",    int'(bus_e.dout),    int'(me.dout));
            chk("even_par_err", int'(bus_e.par_err), int'(me.par_err));
            chk("even_frm_err", int'(bus_e.frm_err), int'(me.frm_err));
            chk("even_err_cnt", int'(bus_e.err_cnt), me.err_cnt);
         end
      end else begin
         chk("even_flags_idle", int'({bus_e.par_err, bus_e.frm_err}), 0);
      end

      if (bus_o.dout_valid) begin
         if (q_o.size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL odd_unexpected_dout_valid: got dout 0x%0h, expected no frame (t=%0t)",
                     bus_o.dout, $time);
         end else begin
            mo = q_o.pop_front();
            chk("odd_dout",    int'(bus_o.dout),    int'(mo.dout));
            chk("odd_par_err", int'(bus_o.par_err), int'(mo.par_err));
            chk("odd_frm_err", int'(bus_o.frm_err), int'(mo.frm_err));
            chk("odd_err_cnt", int'(bus_o.err_cnt), mo.err_cnt);
         end
      end else begin
         chk("odd_flags_idle", int'({bus_o.par_err, bus_o.frm_err}), 0);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] d;
      bus_e.sin = 1'b1; bus_e.sin_valid = 1'b0; bus_e.err_clr = 1'b0;
      bus_o.sin = 1'b1; bus_o.sin_valid = 1'b0; bus_o.err_clr = 1'b0;
      do_reset();

      // Directed frames
      send_frame(8'hA5, 1'b0, 1'b1, 0, 0, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b1, 0, 0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0, 0, 0, 1'b0);
      send_frame(8'h01, 1'b1, 1'b1, 0, 0, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b1, 5, 3, 1'b0);

      // Abort after the 4th data bit; nothing may be presented for it
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom), 1'b0);
      do_reset();
      send_frame(8'h5A, 1'b0, 1'b1, 0, 0, 1'b0);
      chk("err_cnt_after_abort", int'(bus_e.err_cnt), 0);

      // Saturation: parity bit chosen wrong for even, right for odd
      for (int k = 0; k < 257; k++) begin
         d = DW'($urandom);
         send_frame(d, ~^d, 1'b1, 0, 0, 1'b0);
      end
      chk("err_cnt_saturated", int'(bus_e.err_cnt), 255);
      d = DW'($urandom);
      send_frame(d, ~^d, 1'b1, 0, 0, 1'b1);
      chk("err_cnt_clr_with_inc", int'(bus_e.err_cnt), 1);
      drive(1'b0, 1'b0, 1'b1);
      cnt_e = 0;
      cnt_o = 0;
      chk("err_cnt_clr_even", int'(bus_e.err_cnt), 0);
      chk("err_cnt_clr_odd",  int'(bus_o.err_cnt), 0);

      // Random frames with gaps, idle ones, occasional framing errors and clears
      for (int k = 0; k < 60; k++) begin
         d = DW'($urandom);
         send_frame(d, 1'($urandom), 1'($urandom_range(7, 0) != 0), 3,
                    int'($urandom_range(2, 0)), $urandom_range(9, 0) == 0);
      end

      repeat (3) drive(1'b0, 1'b0, 1'b0);
      chk("even_frames_all_seen", q_e.size(), 0);
      chk("odd_frames_all_seen",  q_o.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
